// File: rtl/lsu_sequencer.sv
// Load/store sequencer for an RV64I data port.
// A load reads the doubleword and extracts/extends the addressed lane. A sub-word store
// does a read-modify-write of the doubleword. A doubleword store writes directly.
// Illegal or misaligned requests abort without touching memory.
module lsu_sequencer #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    input  logic [63:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [63:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [63:0]       load_result,
    output logic              misaligned,
    output logic              illegal
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone, StErr} state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] store_data_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] ld_val;
    logic [63:0] st_mask;
    logic [63:0] merged;

    // Classify the incoming request; illegal encodings take priority over alignment.
    always_comb begin
        req_illegal = is_store ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = addr[0];
            2'b10:   req_misaligned = |addr[1:0];
            default: req_misaligned = |addr[2:0];
        endcase
    end

    // Extract the addressed lane from the read doubleword and build the store merge.
    always_comb begin
        shamt = {off_q, 3'b000};
        lane  = mem_rdata >> shamt;
        case (funct3_q)
            3'b000:  ld_val = {{56{lane[7]}}, lane[7:0]};
            3'b001:  ld_val = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ld_val = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ld_val = {56'd0, lane[7:0]};
            3'b101:  ld_val = {48'd0, lane[15:0]};
            3'b110:  ld_val = {32'd0, lane[31:0]};
            default: ld_val = lane;
        endcase
        case (funct3_q[1:0])
            2'b00:   st_mask = 64'h0000_0000_0000_00ff;
            2'b01:   st_mask = 64'h0000_0000_0000_ffff;
            2'b10:   st_mask = 64'h0000_0000_ffff_ffff;
            default: st_mask = 64'hffff_ffff_ffff_ffff;
        endcase
        merged = (mem_rdata & ~(st_mask << shamt)) | ((store_data_q & st_mask) << shamt);
    end

    // Sequencer FSM; every output is registered alongside the state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 3'd0;
            store_data_q <= 64'd0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_wdata    <= 64'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            load_result  <= 64'd0;
            misaligned   <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        is_store_q   <= is_store;
                        funct3_q     <= funct3;
                        off_q        <= addr[2:0];
                        store_data_q <= store_data;
                        mem_addr     <= {addr[ADDR_W-1:3], 3'b000};
                        busy         <= 1'b1;
                        if (req_illegal) begin
                            illegal <= 1'b1;
                            done    <= 1'b1;
                            state   <= StErr;
                        end else if (req_misaligned) begin
                            misaligned <= 1'b1;
                            done       <= 1'b1;
                            state      <= StErr;
                        end else if (is_store && funct3[1:0] == 2'b11) begin
                            // Full doubleword store needs no read-modify-write.
                            mem_wr    <= 1'b1;
                            mem_wdata <= store_data;
                            state     <= StWrite;
                        end else begin
                            state <= StRead;
                        end
                    end
                end
                StRead: state <= StWait;
                StWait: begin
                    if (is_store_q) begin
                        mem_wr    <= 1'b1;
                        mem_wdata <= merged;
                        state     <= StWrite;
                    end else begin
                        load_result <= ld_val;
                        done        <= 1'b1;
                        state       <= StDone;
                    end
                end
                StWrite: begin
                    mem_wr <= 1'b0;
                    done   <= 1'b1;
                    state  <= StDone;
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                StErr: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    illegal    <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_sequencer.md
LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 is_store  input  1  1=store, 0=load.
REQ-006 funct3  input  3  access type (RV64I load/store encoding).
REQ-007 addr  input  ADDR_W  byte address of access.
REQ-008 store_data  input  64  rs2 value; low bytes used per access size.
REQ-009 mem_rdata  input  64  doubleword from data memory; valid the cycle after a read address is driven.
REQ-010 mem_addr  output  ADDR_W  doubleword-aligned address: {addr[ADDR_W-1:3], 3'b000}.
REQ-011 mem_wr  output  1  write strobe, one cycle.
REQ-012 mem_wdata  output  64  full doubleword to write.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 load_result  output  64  extended load value; valid when done=1; held until next accepted start.
REQ-016 misaligned  output  1  with done: access aborted, alignment fault.
REQ-017 illegal  output  1  with done: access aborted, unsupported funct3.

Function
REQ-018 States: IDLE, READ, WAIT, WRITE, DONE, ERR.
REQ-019 IDLE + start: latch is_store, funct3, addr, store_data; select next state per REQ-020 to REQ-023.
REQ-020 Illegal funct3 (load 3'b111; store funct3[2]=1) -> ERR with illegal=1; checked before alignment.
REQ-021 Misaligned: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; violation -> ERR with misaligned=1.
REQ-022 Legal load, or store sb/sh/sw -> READ; store sd -> WRITE.
REQ-023 No memory access (mem_wr=0) in ERR; ERR -> IDLE with done=1 for that cycle.
REQ-024 READ: drive mem_addr, mem_wr=0; -> WAIT.
REQ-025 WAIT: register mem_rdata; load -> DONE, store -> WRITE.
REQ-026 Byte lane offset = addr[2:0]. Loads select bytes [8*off +: size] from captured doubleword.
REQ-027 Extension: lb/lh/lw sign-extend by bit 7/15/31; lbu/lhu/lwu zero-fill 56/48/32 bits; ld passes 64 bits.
REQ-028 Sub-word store merge: captured doubleword with store_data low 8/16/32 bits replacing lane at offset; other bytes unchanged.
REQ-029 WRITE: mem_wr=1 exactly one cycle, mem_addr aligned, mem_wdata = merged (sd: store_data); -> DONE.
REQ-030 DONE: done=1 one cycle; load_result updated for loads, unchanged for stores; -> IDLE.
REQ-031 Latency from start cycle T: load done at T+3; sb/sh/sw done at T+4 (mem_wr at T+3); sd done at T+2 (mem_wr at T+1); fault done at T+1.
REQ-032 start while busy=1 ignored and not queued; start in DONE/ERR cycle ignored.
REQ-033 misaligned/illegal are 0 outside ERR; done is 0 outside DONE/ERR.

Reset
REQ-034 reset=1 at clock edge: state=IDLE, busy=0, done=0, mem_wr=0, mem_wdata=0, mem_addr=0, load_result=0, misaligned=0, illegal=0, latched fields cleared.
REQ-035 Reset mid-operation (any state) aborts the access; no mem_wr asserted after the reset edge; no done pulse for aborted access.
REQ-036 reset has priority over start in the same cycle.

Verification
REQ-037 lb addr=0x1003, mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, done at T+3, load_result=0xFFFF_FFFF_FFFF_FF80.
REQ-038 lhu addr=0x2006, mem_rdata=0xABCD_0000_0000_0000 -> load_result=0x0000_0000_0000_ABCD; lh same -> 0xFFFF_FFFF_FFFF_ABCD.
REQ-039 sh addr=0x3002, store_data=0x1234, mem_rdata=0x1111_1111_1111_1111 -> mem_wr at T+3, mem_wdata=0x1111_1111_1234_1111, done at T+4.
REQ-040 sd addr=0x4000, store_data=0xDEAD_BEEF_CAFE_F00D -> no read, mem_wr at T+1 with that data, done at T+2.
REQ-041 lw addr=0x5002 -> done+misaligned at T+1, mem_wr never asserted; load funct3=3'b111 -> done+illegal at T+1.
REQ-042 sb started, reset asserted in WAIT -> next cycle IDLE, all outputs zero, no mem_wr, no done; second start during busy ignored.
